// File: rtl/satd_pkg.sv
// Shared constants and width helpers for the SATD Hadamard datapath.
//   HAD_N          : transform length (lanes per row)
//   had_w(w, s)    : signed width of the coefficients after butterfly layer s
//                    (s=0 is the raw difference, WIDTH+1 bits)
//   satd_w(w, r)   : width of a block SATD value for r rows per block
package satd_pkg;

    localparam int HAD_N = 8;

    function automatic int had_w(input int width, input int stage);
        return width + 1 + stage;
    endfunction

    function automatic int satd_w(input int width, input int rows);
        return width + 6 + $clog2(rows);
    endfunction

endpackage

// File: rtl/hadamard8_stage.sv
// One registered butterfly layer of the 8-point Hadamard transform.
// Lanes are paired at distance DIST inside groups of 2*DIST: the lower lane
// of a pair receives the sum, the upper lane the difference. Output is one
// bit wider than the input, so the layer is exact.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears valid and data)
//   flush      : drops the valid bit at the next edge (block abort)
//   in_valid   : din holds a valid row
//   din        : HAD_N signed lanes, IN_W bits
//   out_valid  : dout holds a valid row
//   dout       : HAD_N signed lanes, IN_W+1 bits
module hadamard8_stage
    import satd_pkg::*;
#(
    parameter int IN_W = 9,
    parameter int DIST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] din  [HAD_N],
    output logic                   out_valid,
    output logic signed [IN_W:0]   dout [HAD_N]
);

    logic signed [IN_W:0] bf [HAD_N];

    for (genvar i = 0; i < HAD_N; i++) begin : g_bf
        if (((i / DIST) % 2) == 0) begin : g_sum
            assign bf[i] = (IN_W+1)'(din[i]) + (IN_W+1)'(din[i+DIST]);
        end else begin : g_diff
            assign bf[i] = (IN_W+1)'(din[i-DIST]) - (IN_W+1)'(din[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            for (int i = 0; i < HAD_N; i++) dout[i] <= '0;
        end else begin
            out_valid <= in_valid & ~flush;
            if (in_valid) dout <= bf;
        end
    end

endmodule

// File: rtl/hadamard_satd_acc.sv
// SATD accumulator: registers a row of 8 signed differences, runs it through
// three butterfly layers (8-point unnormalised Hadamard), sums the absolute
// coefficients and accumulates ROWS rows into one SATD value per block.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clear           : block abort (flushes pipeline, accumulator, row counter)
//   in_valid        : diff_0..diff_7 carry a row this cycle
//   diff_0..diff_7  : signed differences, WIDTH+1 bits
//   out_valid       : one-cycle strobe, satd holds a finished block sum
//   satd            : unsigned block SATD, held between strobes
//   row_idx         : rows already accumulated into the current block
// Latency: a row sampled at edge t reaches the accumulator at edge t+5.
module hadamard_satd_acc
    import satd_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int ROWS   = 8,
    localparam int SATD_W = satd_w(WIDTH, ROWS),
    localparam int RIDX_W = $clog2(ROWS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [WIDTH:0]   diff_0,
    input  logic signed [WIDTH:0]   diff_1,
    input  logic signed [WIDTH:0]   diff_2,
    input  logic signed [WIDTH:0]   diff_3,
    input  logic signed [WIDTH:0]   diff_4,
    input  logic signed [WIDTH:0]   diff_5,
    input  logic signed [WIDTH:0]   diff_6,
    input  logic signed [WIDTH:0]   diff_7,
    output logic                    out_valid,
    output logic [SATD_W-1:0]       satd,
    output logic [RIDX_W-1:0]       row_idx
);

    localparam int W0    = had_w(WIDTH, 0);
    localparam int W1    = had_w(WIDTH, 1);
    localparam int W2    = had_w(WIDTH, 2);
    localparam int W3    = had_w(WIDTH, 3);
    localparam int SUM_W = WIDTH + 6;

    // Magnitude after sign extension to the row-sum width, so the
    // two's-complement negate of the most negative coefficient is exact.
    function automatic logic [SUM_W-1:0] mag(input logic signed [W3-1:0] x);
        logic signed [SUM_W-1:0] xe;
        xe = SUM_W'(x);
        if (xe < 0) xe = -xe;
        return $unsigned(xe);
    endfunction

    logic                 vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;
    logic signed [W0-1:0] d_p0 [HAD_N];
    logic signed [W1-1:0] d_p1 [HAD_N];
    logic signed [W2-1:0] d_p2 [HAD_N];
    logic signed [W3-1:0] d_p3 [HAD_N];
    logic [SUM_W-1:0]     row_sum_p4;
    logic [SATD_W-1:0]    acc;

    // Stage p0: input row register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            for (int i = 0; i < HAD_N; i++) d_p0[i] <= '0;
        end else begin
            vld_p0 <= in_valid & ~clear;
            if (in_valid)
                d_p0 <= '{diff_0, diff_1, diff_2, diff_3,
                          diff_4, diff_5, diff_6, diff_7};
        end
    end

    // Stages p1..p3: butterfly layers at distance 4, 2, 1
    hadamard8_stage #(.IN_W(W0), .DIST(4)) u_bf4 (
        .clk(clk), .rst(rst), .flush(clear),
        .in_valid(vld_p0), .din(d_p0), .out_valid(vld_p1), .dout(d_p1)
    );

    hadamard8_stage #(.IN_W(W1), .DIST(2)) u_bf2 (
        .clk(clk), .rst(rst), .flush(clear),
        .in_valid(vld_p1), .din(d_p1), .out_valid(vld_p2), .dout(d_p2)
    );

    hadamard8_stage #(.IN_W(W2), .DIST(1)) u_bf1 (
        .clk(clk), .rst(rst), .flush(clear),
        .in_valid(vld_p2), .din(d_p2), .out_valid(vld_p3), .dout(d_p3)
    );

    logic [SUM_W-1:0] mag_c  [HAD_N];
    logic [SUM_W-1:0] lvl1_c [4];
    logic [SUM_W-1:0] lvl2_c [2];
    logic [SUM_W-1:0] row_sum_c;

    always_comb begin
        for (int i = 0; i < HAD_N; i++) mag_c[i]  = mag(d_p3[i]);
        for (int i = 0; i < 4; i++)     lvl1_c[i] = mag_c[2*i] + mag_c[2*i+1];
        for (int i = 0; i < 2; i++)     lvl2_c[i] = lvl1_c[2*i] + lvl1_c[2*i+1];
        row_sum_c = lvl2_c[0] + lvl2_c[1];
    end

    // Stage p4: registered sum of absolute coefficients
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p4     <= 1'b0;
            row_sum_p4 <= '0;
        end else begin
            vld_p4 <= vld_p3 & ~clear;
            if (vld_p3) row_sum_p4 <= row_sum_c;
        end
    end

    // Stage p5: block accumulator, row counter and output register.
    // The last row of a block bypasses acc so the next block can start
    // accumulating on the very next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            row_idx   <= '0;
            satd      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                acc     <= '0;
                row_idx <= '0;
            end else if (vld_p4) begin
                if (row_idx == RIDX_W'(ROWS - 1)) begin
                    satd      <= acc + SATD_W'(row_sum_p4);
                    out_valid <= 1'b1;
                    acc       <= '0;
                    row_idx   <= '0;
                end else begin
                    acc     <= acc + SATD_W'(row_sum_p4);
                    row_idx <= row_idx + RIDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hadamard_satd_acc.sv
// Directed and randomised bench for hadamard_satd_acc (WIDTH=8, ROWS=8).
// A reference row sum is computed from the Hadamard matrix definition
// (sign of H[i][j] = parity of popcount(i & j)).
module tb_hadamard_satd_acc;

    localparam int WIDTH  = 8;
    localparam int ROWS   = 8;
    localparam int SATD_W = WIDTH + 6 + $clog2(ROWS);
    localparam int RIDX_W = $clog2(ROWS);

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clear = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [WIDTH:0]   diff_0 = '0, diff_1 = '0, diff_2 = '0, diff_3 = '0;
    logic signed [WIDTH:0]   diff_4 = '0, diff_5 = '0, diff_6 = '0, diff_7 = '0;
    logic                    out_valid;
    logic [SATD_W-1:0]       satd;
    logic [RIDX_W-1:0]       row_idx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int got_v[$], got_c[$], exp_v[$], exp_c[$];
    int m_acc = 0;
    int m_rows = 0;

    hadamard_satd_acc #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .diff_0(diff_0), .diff_1(diff_1), .diff_2(diff_2), .diff_3(diff_3),
        .diff_4(diff_4), .diff_5(diff_5), .diff_6(diff_6), .diff_7(diff_7),
        .out_valid(out_valid), .satd(satd), .row_idx(row_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            got_v.push_back(int'(satd));
            got_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_rowsum(input int d[8]);
        int s, c;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            c = 0;
            for (int j = 0; j < 8; j++)
                c += ($countones(i & j) % 2) ? -d[j] : d[j];
            s += (c < 0) ? -c : c;
        end
        return s;
    endfunction

    task automatic set_diffs(input int d[8]);
        diff_0 = 9'(d[0]); diff_1 = 9'(d[1]); diff_2 = 9'(d[2]); diff_3 = 9'(d[3]);
        diff_4 = 9'(d[4]); diff_5 = 9'(d[5]); diff_6 = 9'(d[6]); diff_7 = 9'(d[7]);
    endtask

    task automatic send_row(input int d[8]);
        in_valid = 1'b1;
        set_diffs(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
        m_acc += ref_rowsum(d);
        m_rows++;
        if (m_rows == ROWS) begin
            exp_v.push_back(m_acc);
            exp_c.push_back(cyc + 5);
            m_acc = 0;
            m_rows = 0;
        end
    endtask

    task automatic idle(input int n);
        int g[8];
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) g[i] = int'($urandom_range(0, 510)) - 255;
        set_diffs(g);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int d0[8], input int drest[8]);
        send_row(d0);
        for (int r = 1; r < ROWS; r++) send_row(drest);
    endtask

    task automatic drain(input string tag);
        repeat (10) @(posedge clk);
        #1;
        check({tag, "_npulse"}, got_v.size(), exp_v.size());
        while (got_v.size() > 0 && exp_v.size() > 0) begin
            check({tag, "_satd"}, got_v.pop_front(), exp_v.pop_front());
            check({tag, "_lat"}, got_c.pop_front(), exp_c.pop_front());
        end
        got_v.delete(); got_c.delete(); exp_v.delete(); exp_c.delete();
    endtask

    initial begin
        int z[8], imp[8], dc[8], alt[8], nalt[8], big[8], r[8];
        for (int i = 0; i < 8; i++) begin
            z[i]    = 0;
            imp[i]  = (i == 0) ? 1 : 0;
            dc[i]   = 255;
            alt[i]  = (i % 2 == 0) ? 255 : -255;
            nalt[i] = -alt[i];
            big[i]  = -255;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_satd", satd, 0);
        check("rst_row_idx", row_idx, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        send_block(z, z);
        drain("zero");
        check("zero_satd_lit", satd, 0);

        send_block(imp, z);
        drain("impulse");
        check("impulse_satd_lit", satd, 8);

        send_block(dc, dc);
        drain("dc");
        check("dc_satd_lit", satd, 16320);

        send_block(imp, z);
        drain("impulse2");
        send_block(alt, alt);
        drain("alt");
        check("alt_satd_lit", satd, 16320);

        send_block(imp, z);
        drain("impulse3");
        send_block(nalt, nalt);
        drain("nalt");
        check("nalt_satd_lit", satd, 16320);

        // Abort after 5 rows; a row presented together with clear is discarded.
        for (int k = 0; k < 5; k++) send_row(dc);
        clear = 1'b1;
        in_valid = 1'b1;
        set_diffs(big);
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        m_acc = 0;
        m_rows = 0;
        repeat (8) @(posedge clk);
        #1;
        check("clr_row_idx", row_idx, 0);
        check("clr_satd_held", satd, 16320);
        check("clr_no_pulse", got_v.size(), 0);
        send_block(imp, imp);
        drain("after_clear");
        check("after_clear_lit", satd, 64);

        // Reset after 3 rows.
        for (int k = 0; k < 3; k++) send_row(dc);
        repeat (6) @(posedge clk);
        #1;
        check("mid_row_idx", row_idx, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 0;
        m_rows = 0;
        check("rst2_satd", satd, 0);
        check("rst2_row_idx", row_idx, 0);
        send_block(imp, imp);
        drain("after_rst");
        check("after_rst_lit", satd, 64);

        // Random rows with bubbles.
        for (int k = 0; k < ROWS; k++) begin
            for (int i = 0; i < 8; i++) r[i] = int'($urandom_range(0, 510)) - 255;
            send_row(r);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        drain("rand_bub");

        // Back-to-back blocks, no idle cycles.
        for (int k = 0; k < 2 * ROWS; k++) begin
            for (int i = 0; i < 8; i++) r[i] = int'($urandom_range(0, 510)) - 255;
            send_row(r);
        end
        drain("b2b");

        // Longer random run with bubbles spanning several blocks.
        for (int k = 0; k < 3 * ROWS; k++) begin
            for (int i = 0; i < 8; i++) r[i] = int'($urandom_range(0, 510)) - 255;
            send_row(r);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
        end
        drain("rand_multi");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
